// File: rtl/alu32.sv
// alu32: 32-bit ripple-carry ALU with registered result, carry, zero and overflow flags
module alu32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic [2:0]       command,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             zero,
    output logic             overflow
);
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, XOR = 3'd2, SLT = 3'd3,
                           AND = 3'd4, NAND = 3'd5, NOR = 3'd6, OR = 3'd7;
    logic             sub, arith, ovf, less, cout_next, ovf_next;
    logic [WIDTH-1:0] b_eff, sum, res_next;
    logic [WIDTH:0]   c;
    assign sub   = command == SUB || command == SLT;
    assign arith = command == ADD || command == SUB;
    assign b_eff = operandB ^ {WIDTH{sub}};
    assign c[0]  = sub;
    // One slice per bit: full adder plus logic functions and the result mux
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        logic a, b, slt_bit;
        assign a        = operandA[i];
        assign b        = operandB[i];
        assign sum[i]   = a ^ b_eff[i] ^ c[i];
        assign c[i+1]   = (a & b_eff[i]) | (c[i] & (a ^ b_eff[i]));
        assign slt_bit  = (i == 0) ? less : 1'b0;
        assign res_next[i] = arith            ? sum[i]    :
                             command == XOR   ? a ^ b     :
                             command == SLT   ? slt_bit   :
                             command == AND   ? a & b     :
                             command == NAND  ? ~(a & b)  :
                             command == NOR   ? ~(a | b)  :
                                                a | b;
    end
    // Sign of the difference corrected by overflow gives a true signed compare
    assign ovf       = c[WIDTH] ^ c[WIDTH-1];
    assign less      = sum[WIDTH-1] ^ ovf;
    assign cout_next = arith & c[WIDTH];
    assign ovf_next  = arith & ovf;
    always_ff @(posedge clk) begin
        if (reset) begin
            result   <= '0;
            carryout <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            result   <= res_next;
            carryout <= cout_next;
            zero     <= res_next == '0;
            overflow <= ovf_next;
        end
    end
endmodule

// File: tb/tb_alu32.sv
// tb_alu32: directed and randomized checks of alu32 against an arithmetic reference model
module tb_alu32;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] operandA, operandB;
    logic [2:0]  command;
    logic [31:0] result;
    logic        carryout, zero, overflow;
    int          n_checks = 0;
    int          n_fail = 0;

    alu32 dut (
        .clk(clk), .reset(reset), .operandA(operandA), .operandB(operandB),
        .command(command), .result(result), .carryout(carryout), .zero(zero),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {result, carryout, overflow, zero} from plain arithmetic on the operation rules
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd);
        logic [32:0] s;
        logic [31:0] r;
        logic co, ov;
        co = 1'b0;
        ov = 1'b0;
        case (cmd)
            3'd0: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[31:0];
                co = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                r  = a - b;
                co = a >= b;
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r = a ^ b;
            3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: r = a & b;
            3'd5: r = ~(a & b);
            3'd6: r = ~(a | b);
            default: r = a | b;
        endcase
        return {r, co, ov, r == 32'd0};
    endfunction

    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd);
        operandA = a;
        operandB = b;
        command  = cmd;
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] cmd, input logic [31:0] r, input logic co,
                            input logic ov, input logic z);
        apply(a, b, cmd);
        check({tag, ".result"}, result, r);
        check({tag, ".carryout"}, {31'd0, carryout}, {31'd0, co});
        check({tag, ".overflow"}, {31'd0, overflow}, {31'd0, ov});
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, z});
    endtask

    task automatic randomized(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd);
        logic [34:0] e;
        e = model(a, b, cmd);
        apply(a, b, cmd);
        check("rand.result", result, e[34:3]);
        check("rand.carryout", {31'd0, carryout}, {31'd0, e[2]});
        check("rand.overflow", {31'd0, overflow}, {31'd0, e[1]});
        check("rand.zero", {31'd0, zero}, {31'd0, e[0]});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] a, b;
        reset = 1'b1;
        directed("reset", 32'd5, 32'd7, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        directed("post_reset", 32'd5, 32'd7, 3'd0, 32'd12, 1'b0, 1'b0, 1'b0);
        directed("slt_0_1", 32'd0, 32'd1, 3'd3, 32'd1, 1'b0, 1'b0, 1'b0);
        directed("slt_1_0", 32'd1, 32'd0, 3'd3, 32'd0, 1'b0, 1'b0, 1'b1);
        directed("slt_min_1", 32'h8000_0000, 32'd1, 3'd3, 32'd1, 1'b0, 1'b0, 1'b0);
        directed("slt_max_m1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'd3, 32'd0, 1'b0, 1'b0, 1'b1);
        directed("add_ovf", 32'h7FFF_FFFF, 32'd1, 3'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        directed("add_carry", 32'hFFFF_FFFF, 32'd1, 3'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        directed("add_both", 32'h8000_0000, 32'h8000_0000, 3'd0, 32'd0, 1'b1, 1'b1, 1'b1);
        directed("sub_eq", 32'd5, 32'd5, 3'd1, 32'd0, 1'b1, 1'b0, 1'b1);
        directed("sub_neg", 32'd3, 32'd5, 3'd1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        directed("sub_ovf", 32'h8000_0000, 32'd1, 3'd1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        directed("xor", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd2, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0);
        directed("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd4, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
        directed("nand", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd5, 32'h0FFF_0FFF, 1'b0, 1'b0, 1'b0);
        directed("nor", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd6, 32'h000F_000F, 1'b0, 1'b0, 1'b0);
        directed("or", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd7, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        directed("mid_reset", 32'hFFFF_FFFF, 32'd1, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        directed("after_mid_reset", 32'h8000_0000, 32'd1, 3'd1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            a = pick();
            b = ($urandom_range(0, 3) == 0) ? a : pick();
            randomized(a, b, 3'($urandom_range(0, 7)));
        end
        randomized(32'h1234_5678, 32'h1234_5678, 3'd2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
